loop_playback_reader: RTL
=========================

# loop_playback_reader

Playback-side SDRAM reader for the loop path: the read-side counterpart of the loop recorder that writes captured samples into SDRAM. While `play` is high it streams a loop of `loop_len` 32-bit words, starting at `base_addr`, out of SDRAM over the Avalon-MM master port. It honours `waitrequest`/`readdatavalid` and buffers the returned words in a small FIFO. It then hands one sample per `sample_req` to the audio-out path, which feeds the left and right `Audio_Controller` channels.

## Interface
- `ADDR_W`, 25: SDRAM word-address width.
- `FIFO_DEPTH`, 8: prefetch FIFO entries; power of two, ≥2.
- `clk` in 1: system clock, CLOCK_50 domain; single clock.
- `reset` in 1: asynchronous, active-low reset.
- `play` in 1: level; high = stream loop, low = stop and flush.
- `base_addr` in ADDR_W: first word of the loop.
- `loop_len` in ADDR_W: loop length in words; 0 = nothing to play.
- `avm_address` out ADDR_W: read address.
- `avm_read_n` out 1: active-low read request.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: returned word.
- `avm_readdatavalid` in 1: `avm_readdata` is valid this cycle.
- `sample_req` in 1: one-cycle pop strobe from audio-out (`audio_out_allowed` qualified).
- `sample_out` out 32: sample delivered to both channels.
- `sample_valid` out 1: one-cycle pulse, `sample_out` updated from FIFO.
- `underrun` out 1: one-cycle pulse, request made with FIFO empty.
- `position` out ADDR_W: loop index of the last delivered sample (for HEX display).

## Operation
- **Reset values:** `avm_read_n`=1, `avm_address`=0, `sample_out`=0, `sample_valid`=0, `underrun`=0, `position`=0.
- **Internal reset state:** `rd_idx`=0, `outstanding`=0, FIFO empty, FSM in IDLE.
- **Credit rule:** `fifo_count + outstanding < FIFO_DEPTH` is required to issue a read. FIFO overflow is therefore impossible.
- **IDLE:** go to ISSUE when `play`=1 and `loop_len`≠0.
- **ISSUE:** drive `avm_read_n`=0 and `avm_address = base_addr + rd_idx` (modulo 2^ADDR_W) while credit exists.
  - A read is accepted on an edge where `avm_read_n`=0 and `avm_waitrequest`=0.
  - On acceptance: `outstanding`+1, and `rd_idx` becomes 0 if `rd_idx ≥ loop_len-1`, otherwise `rd_idx`+1.
  - While `avm_waitrequest`=1, address and `avm_read_n` are held unchanged.
  - Without credit, `avm_read_n`=1.
  - `play`=0 → DRAIN. The in-flight request is dropped only if not held by `waitrequest`.
- **DRAIN:** `avm_read_n`=1. Wait for `outstanding`=0, then flush the FIFO, set `rd_idx`=0 and `position`=0, and go to IDLE.
- **Read data return:** `avm_readdatavalid`=1 pushes `avm_readdata` into the FIFO and decrements `outstanding`. If `outstanding`=0, the word is ignored (stale data after reset).
- **Sample request, FIFO non-empty:** pop. `sample_out` takes the head, `sample_valid` pulses, and `position` advances with the same wrap rule as `rd_idx`.
- **Sample request, FIFO empty:** `sample_out`=0 and `underrun` pulses. `position` is unchanged.
- **Requests outside ISSUE:** a `sample_req` in IDLE or DRAIN is served from the FIFO if it is non-empty. Otherwise `sample_out`=0 with no underrun pulse.
- **Simultaneous push and pop:** `fifo_count` is unchanged and data order is preserved.
- **`loop_len` change mid-play:** applies at the next acceptance; an index ≥ the new length wraps to 0 immediately.
- **`base_addr` change:** applies to the next issued address only, never to a held request.

## Timing
- Read request is asserted one cycle after credit appears or after IDLE→ISSUE.
- Back-to-back reads are possible every cycle while credit exists and `waitrequest`=0.
- `sample_out`, `sample_valid` and `underrun` are registered one cycle after `sample_req`.
- A word returned on cycle N is poppable by a `sample_req` on cycle N+1.
- `outstanding` is at most FIFO_DEPTH; the slave's read latency is arbitrary.

## Test plan
- **Basic stream:** `base_addr`=0x100, `loop_len`=4, slave returns addr+1 with 2-cycle latency, `sample_req` every 16 cycles → `sample_out` 0x101,0x102,0x103,0x104,0x101…; `position` 0,1,2,3,0.
- **Waitrequest hold:** `waitrequest` high 5 cycles on the 2nd read → `avm_address`=0x101 and `avm_read_n`=0 are stable throughout, with exactly one acceptance.
- **Credit limit:** slave never asserts `readdatavalid`, FIFO_DEPTH=8 → exactly 8 reads accepted, then `avm_read_n`=1.
- **Underrun:** first `sample_req` 1 cycle after `play` rises → `underrun`=1 pulse, `sample_out`=0.
- **Stop and flush:** drop `play` with 3 reads outstanding → no new reads; after the 3 returns, FIFO empty and `position`=0. A subsequent `play` restarts at 0x100.
- **Reset mid-operation:** assert `reset`=0 with 2 reads outstanding → all outputs at reset values immediately. A late `readdatavalid` after release is ignored, and `fifo_count` stays 0.

Source files
------------

// File: rtl/loop_playback_reader.sv
// loop_playback_reader: fetches a loop of 32-bit words from SDRAM over an
// Avalon-MM read master, buffers them in a small prefetch FIFO, and hands one
// word per sample request to the audio-out path.
module loop_playback_reader #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] loop_len,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read_n,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              sample_req,
    output logic [31:0]       sample_out,
    output logic              sample_valid,
    output logic              underrun,
    output logic [ADDR_W-1:0] position
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d, issue_idx;
    logic [ADDR_W-1:0] pop_idx_q;
    logic [ADDR_W-1:0] avm_address_q, position_q;
    logic              avm_read_n_q;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]       sample_out_q;
    logic              sample_valid_q, underrun_q;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [CNT_W:0]    credit_sum;

    logic accept, held, push, pop, fifo_empty, credit;

    // Loop index advance: wrap to 0 once the last word of the loop is reached.
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx,
                                                   input logic [ADDR_W-1:0] len);
        if (len == '0 || idx >= len - 1'b1)
            return '0;
        return idx + 1'b1;
    endfunction

    assign accept     = !avm_read_n_q && !avm_waitrequest;
    assign held       = !avm_read_n_q && avm_waitrequest;
    // Returns with nothing outstanding are stale words from before a reset.
    assign push       = avm_readdatavalid && (outstanding_q != '0);
    assign fifo_empty = (count_q == '0);
    assign pop        = sample_req && !fifo_empty;

    // Post-edge occupancy, used so a new request never exceeds the FIFO space.
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(push);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_idx_d      = accept ? next_idx(rd_idx_q, loop_len) : rd_idx_q;
        // A shortened loop pulls an out-of-range index straight back to 0.
        issue_idx     = (rd_idx_d >= loop_len) ? '0 : rd_idx_d;
        credit_sum    = {1'b0, count_d} + {1'b0, outstanding_d};
        credit        = (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
    end

    // Prefetch storage; write side only, read is the head at rd_ptr.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= avm_readdata;
    end

    // Control FSM, FIFO bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rd_idx_q       <= '0;
            pop_idx_q      <= '0;
            avm_address_q  <= '0;
            avm_read_n_q   <= 1'b1;
            outstanding_q  <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            position_q     <= '0;
        end else begin
            outstanding_q  <= outstanding_d;
            count_q        <= count_d;
            rd_idx_q       <= rd_idx_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;

            sample_valid_q <= pop;
            underrun_q     <= sample_req && fifo_empty && (state_q == ISSUE);
            if (pop) begin
                sample_out_q <= fifo_mem[rd_ptr_q];
                position_q   <= pop_idx_q;
                pop_idx_q    <= next_idx(pop_idx_q, loop_len);
            end else if (sample_req) begin
                sample_out_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    avm_read_n_q <= 1'b1;
                    if (play && loop_len != '0)
                        state_q <= ISSUE;
                end
                ISSUE: begin
                    if (!play)
                        state_q <= DRAIN;
                    // A request stalled by waitrequest must stay untouched.
                    if (!held) begin
                        if (play && credit) begin
                            avm_read_n_q  <= 1'b0;
                            avm_address_q <= base_addr + issue_idx;
                            rd_idx_q      <= issue_idx;
                        end else begin
                            avm_read_n_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!held)
                        avm_read_n_q <= 1'b1;
                    if (avm_read_n_q && outstanding_q == '0) begin
                        count_q    <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        rd_idx_q   <= '0;
                        pop_idx_q  <= '0;
                        position_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avm_address  = avm_address_q;
    assign avm_read_n   = avm_read_n_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign position     = position_q;
endmodule
